huffman_multi_table_decoder: RTL and testbench
==============================================

# huffman_multi_table_decoder

Parametrised canonical Huffman decoder for the JPEG entropy-decoding path, replacing fixed DC/AC lookup tables with NUM_TABLES runtime-loadable tables (JPEG DHT format: BITS counts plus HUFFVAL list). It sits between the bitstream unpacker and the coefficient builder. It consumes one code bit per cycle over a valid/ready handshake and emits a (run, size) symbol on a second valid/ready handshake. An internal build FSM derives the mincode, maxcode and valptr arrays from loaded BITS counts.

## Interface
- NUM_TABLES, 4, number of independent Huffman tables (e.g. DC0, AC0, DC1, AC1)
- MAX_CODE_LEN, 16, longest legal code length in bits
- MAX_SYMBOLS, 256, HUFFVAL entries per table
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_is_bits  in  1  1: write BITS count; 0: write HUFFVAL entry
- cfg_table  in  clog2(NUM_TABLES)  target table
- cfg_addr  in  8  BITS: length-1 (0..MAX_CODE_LEN-1); HUFFVAL: symbol index
- cfg_data  in  8  count or symbol byte
- cfg_build  in  1  pulse: derive decode arrays for cfg_table
- cfg_ready  out  1  writes and build accepted only when high
- sel_table  in  clog2(NUM_TABLES)  table for next code; sampled with first bit
- in_bit  in  1  code bit, MSB first
- in_valid  in  1  in_bit valid
- in_ready  out  1  bit accepted on in_valid && in_ready
- sym_run  out  4  HUFFVAL[7:4]
- sym_size  out  4  HUFFVAL[3:0]
- sym_len  out  5  matched code length
- sym_valid  out  1  symbol valid; held until sym_ready
- sym_ready  in  1  downstream accept
- err  out  1  one-cycle pulse: no match within MAX_CODE_LEN bits

## Operation
- States: IDLE, DECODE, LOOKUP, OUT, BUILD.
- IDLE: cfg_ready=1, in_ready=1. cfg_we is honoured here only. cfg_build goes to BUILD and takes priority over a same-cycle in_valid. An accepted bit latches sel_table, sets code={bit}, len=1, then runs the match check.
- Match check, applied to each accepted bit's updated code/len, combinational on the registered arrays:
  - hit when len_valid[t][len] && code <= maxcode[t][len];
  - index = valptr[t][len] + code - mincode[t][len], truncated to 8 bits;
  - hit: register index, go to LOOKUP;
  - miss with len < MAX_CODE_LEN: go to or stay in DECODE;
  - miss with len == MAX_CODE_LEN: error handling (see Configuration).
- DECODE: in_ready=1. Each accepted bit updates code=(code<<1)|bit, len+1, then runs the match check.
- LOOKUP: in_ready=0. HUFFVAL read is registered. Go to OUT.
- OUT: sym_valid=1, outputs stable. On sym_ready go to IDLE. in_ready=0.
- BUILD: one length per cycle, L=1..MAX_CODE_LEN. Running code (17 b) and k (9 b) start at 0. Per L:
  - valptr=k, mincode=code;
  - len_valid=(BITS[L]!=0), maxcode=code+BITS[L]-1;
  - code=(code+BITS[L])<<1, k+=BITS[L].
  - After the final length, go to IDLE. cfg_ready=0 and in_ready=0 throughout.
- Reset:
  - clears all len_valid flags (every code errors until built), state→IDLE, code/len discarded;
  - an in-progress build is aborted;
  - BITS/HUFFVAL RAM contents are not reset.

## Timing
- Reset values: in_ready=1, cfg_ready=1, sym_valid=0, err=0, sym_run=0, sym_size=0, sym_len=0.
- Latency: code of length L needs L bit-accept edges. sym_valid rises at the second edge after the final accepted bit. Peak throughput is one symbol per L+2 cycles.
- in_valid gaps stall DECODE without state loss. sym_valid with sym_ready low holds outputs indefinitely.
- cfg_we while cfg_ready=0 is ignored. cfg_build while cfg_ready=0 is ignored.
- BUILD occupies exactly MAX_CODE_LEN cycles.
- err pulses on the edge after the failing bit is accepted. State returns to IDLE on the same edge.

## Configuration
- HUFF_ERR_CHECK_EN defined: a miss at len==MAX_CODE_LEN pulses err, discards the code and returns to IDLE.
- HUFF_ERR_CHECK_EN undefined: err is tied to 0. A miss at MAX_CODE_LEN forces index 0, goes to LOOKUP and emits HUFFVAL[0] with sym_len=MAX_CODE_LEN.

## Test plan
- Load table 0 with JPEG luma DC (BITS L2=1, L3=5, L4..L9=1; HUFFVAL 0..11), build, feed "00" -> run=0, size=0, len=2; "1110" -> size=6, len=4; "011" -> size=2, len=3.
- Load table 1 with luma AC (BITS L2=2, L3=1, L4=3; HUFFVAL 01,02,03,00,04,11), build, sel_table=1, feed "1010" -> run=0, size=0 (EOB); "1100" -> run=1, size=1.
- Build-only: pulse cfg_build -> cfg_ready and in_ready low for exactly 16 cycles, then high again.
- Back-pressure and bubbles: hold sym_ready=0 for 5 cycles -> sym_valid and outputs stable, in_ready=0; toggle in_valid between bits -> same decoded symbols.
- Unbuilt or overlong code:
  - with HUFF_ERR_CHECK_EN, sixteen 1s into DC table -> err pulse after bit 16, no sym_valid;
  - without it -> sym_valid with HUFFVAL[0] and len=16.
- Assert rst mid-code (after 2 bits) and mid-BUILD -> outputs at reset values; subsequent decode of "00" errors until the table is rebuilt.

Source files
------------

// File: rtl/huffman_multi_table_decoder.sv
// huffman_multi_table_decoder
//
// Canonical Huffman decoder with NUM_TABLES runtime-loadable tables in JPEG DHT
// form (BITS counts plus HUFFVAL list). A build pass turns the BITS counts of
// one table into mincode/maxcode/valptr arrays. Code bits then arrive one per
// cycle, MSB first, and each (run, size) symbol leaves on a valid/ready handshake.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   cfg_we        table write strobe (honoured only while cfg_ready)
//   cfg_is_bits   1: cfg_data is BITS[cfg_addr+1]; 0: cfg_data is HUFFVAL[cfg_addr]
//   cfg_table     target table for writes and builds
//   cfg_addr      BITS length-1 or HUFFVAL index
//   cfg_data      count or symbol byte
//   cfg_build     pulse: derive the decode arrays for cfg_table
//   cfg_ready     high only in IDLE
//   sel_table     table for the next code, sampled with its first bit
//   in_bit        code bit; in_valid/in_ready handshake
//   sym_run       HUFFVAL[7:4]
//   sym_size      HUFFVAL[3:0]
//   sym_len       matched code length
//   sym_valid     symbol valid, held until sym_ready
//   err           one-cycle pulse when no code matches within MAX_CODE_LEN bits
//
// Build option:
//   HUFF_ERR_CHECK_EN  when defined, an overlong code pulses err and is dropped.
//                      When undefined, err is tied low and an overlong code
//                      emits HUFFVAL[0] with sym_len = MAX_CODE_LEN.

module huffman_multi_table_decoder #(
    parameter int unsigned NUM_TABLES   = 4,
    parameter int unsigned MAX_CODE_LEN = 16,
    parameter int unsigned MAX_SYMBOLS  = 256,
    localparam int unsigned TW = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic          cfg_is_bits,
    input  logic [TW-1:0] cfg_table,
    input  logic [7:0]    cfg_addr,
    input  logic [7:0]    cfg_data,
    input  logic          cfg_build,
    output logic          cfg_ready,
    input  logic [TW-1:0] sel_table,
    input  logic          in_bit,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [3:0]    sym_run,
    output logic [3:0]    sym_size,
    output logic [4:0]    sym_len,
    output logic          sym_valid,
    input  logic          sym_ready,
    output logic          err
);

    localparam int unsigned CW  = MAX_CODE_LEN + 1;        // running build code width
    localparam int unsigned BLW = $clog2(MAX_CODE_LEN);    // length index width
    localparam int unsigned SW  = $clog2(MAX_SYMBOLS);     // HUFFVAL index width

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StLookup,
        StOut,
        StBuild
    } state_e;

    state_e state_q;

    // Table storage (not reset).
    logic [7:0] bits_mem    [NUM_TABLES][MAX_CODE_LEN];
    logic [7:0] huffval_mem [NUM_TABLES][MAX_SYMBOLS];

    // Derived decode arrays, indexed by length-1. Only the low byte of mincode
    // is kept: it is used solely in the 8-bit truncated index arithmetic.
    logic [7:0]              mincode_q [NUM_TABLES][MAX_CODE_LEN];
    logic [CW-1:0]           maxcode_q [NUM_TABLES][MAX_CODE_LEN];
    logic [7:0]              valptr_q  [NUM_TABLES][MAX_CODE_LEN];
    logic [MAX_CODE_LEN-1:0] len_valid_q [NUM_TABLES];

    // Decode context.
    logic [MAX_CODE_LEN-1:0] code_q;
    logic [4:0]              len_q;
    logic [TW-1:0]           table_q;
    logic [7:0]              index_q;

    // Build context.
    logic [TW-1:0]  build_tbl_q;
    logic [BLW-1:0] build_len_q;
    logic [CW-1:0]  bcode_q;
    logic [8:0]     bk_q;

    // Registered symbol outputs.
    logic [3:0] sym_run_q;
    logic [3:0] sym_size_q;
    logic [4:0] sym_len_q;

    // ------------------------------------------------------------------
    // Handshake outputs decoded from the registered state.
    // ------------------------------------------------------------------
    assign cfg_ready = (state_q == StIdle);
    assign in_ready  = (state_q == StIdle) || (state_q == StDecode);
    assign sym_valid = (state_q == StOut);
    assign sym_run   = sym_run_q;
    assign sym_size  = sym_size_q;
    assign sym_len   = sym_len_q;

    // ------------------------------------------------------------------
    // Match check on the code/len that an accepted bit would produce.
    // ------------------------------------------------------------------
    logic [TW-1:0]           mt_tbl;
    logic [MAX_CODE_LEN-1:0] mt_code;
    logic [4:0]              mt_len;
    logic [4:0]              mt_lm1;
    logic [BLW-1:0]          mt_li;
    logic                    mt_hit;
    logic                    mt_last;
    logic [7:0]              mt_index;

    always_comb begin
        if (state_q == StIdle) begin
            mt_tbl  = sel_table;
            mt_code = {{(MAX_CODE_LEN-1){1'b0}}, in_bit};
            mt_len  = 5'd1;
        end else begin
            mt_tbl  = table_q;
            mt_code = {code_q[MAX_CODE_LEN-2:0], in_bit};
            mt_len  = len_q + 5'd1;
        end
        mt_lm1   = mt_len - 5'd1;
        mt_li    = mt_lm1[BLW-1:0];
        mt_hit   = len_valid_q[mt_tbl][mt_li] &&
                   ({1'b0, mt_code} <= maxcode_q[mt_tbl][mt_li]);
        mt_last  = (mt_len == 5'(MAX_CODE_LEN));
        // Modulo-256 arithmetic, so low bytes are sufficient.
        mt_index = valptr_q[mt_tbl][mt_li] + mt_code[7:0] - mincode_q[mt_tbl][mt_li];
    end

    // ------------------------------------------------------------------
    // Build step for the current length.
    // ------------------------------------------------------------------
    logic [7:0]    b_cnt;
    logic [CW-1:0] b_cnt_w;
    logic [CW-1:0] b_max;
    logic [CW-1:0] b_next_code;
    logic [8:0]    b_next_k;

    always_comb begin
        b_cnt       = bits_mem[build_tbl_q][build_len_q];
        b_cnt_w     = {{(CW-8){1'b0}}, b_cnt};
        b_max       = bcode_q + b_cnt_w - CW'(1);
        b_next_code = (bcode_q + b_cnt_w) << 1;
        b_next_k    = bk_q + {1'b0, b_cnt};
    end

    // ------------------------------------------------------------------
    // Table writes, accepted only in IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q == StIdle)) begin
            if (cfg_is_bits) begin
                if (32'(cfg_addr) < MAX_CODE_LEN) begin
                    bits_mem[cfg_table][cfg_addr[BLW-1:0]] <= cfg_data;
                end
            end else if (32'(cfg_addr) < MAX_SYMBOLS) begin
                huffval_mem[cfg_table][cfg_addr[SW-1:0]] <= cfg_data;
            end
        end
    end

    // Decode arrays written during BUILD; len_valid alone gates their use.
    always_ff @(posedge clk) begin
        if (state_q == StBuild) begin
            mincode_q[build_tbl_q][build_len_q] <= bcode_q[7:0];
            maxcode_q[build_tbl_q][build_len_q] <= b_max;
            valptr_q[build_tbl_q][build_len_q]  <= bk_q[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < int'(NUM_TABLES); t++) begin
                len_valid_q[t] <= '0;
            end
        end else if (state_q == StBuild) begin
            len_valid_q[build_tbl_q][build_len_q] <= (b_cnt != 8'd0);
        end
    end

    // ------------------------------------------------------------------
    // Main FSM with registered outputs.
    // ------------------------------------------------------------------
`ifdef HUFF_ERR_CHECK_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            code_q      <= '0;
            len_q       <= '0;
            table_q     <= '0;
            index_q     <= '0;
            build_tbl_q <= '0;
            build_len_q <= '0;
            bcode_q     <= '0;
            bk_q        <= '0;
            sym_run_q   <= '0;
            sym_size_q  <= '0;
            sym_len_q   <= '0;
`ifdef HUFF_ERR_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
`ifdef HUFF_ERR_CHECK_EN
            err_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle, StDecode: begin
                    if ((state_q == StIdle) && cfg_build) begin
                        // Build wins over a same-cycle code bit.
                        build_tbl_q <= cfg_table;
                        build_len_q <= '0;
                        bcode_q     <= '0;
                        bk_q        <= '0;
                        state_q     <= StBuild;
                    end else if (in_valid) begin
                        code_q  <= mt_code;
                        len_q   <= mt_len;
                        table_q <= mt_tbl;
                        if (mt_hit) begin
                            index_q <= mt_index;
                            state_q <= StLookup;
                        end else if (mt_last) begin
`ifdef HUFF_ERR_CHECK_EN
                            err_q   <= 1'b1;
                            state_q <= StIdle;
`else
                            index_q <= '0;
                            state_q <= StLookup;
`endif
                        end else begin
                            state_q <= StDecode;
                        end
                    end
                end
                StLookup: begin
                    sym_run_q  <= huffval_mem[table_q][index_q[SW-1:0]][7:4];
                    sym_size_q <= huffval_mem[table_q][index_q[SW-1:0]][3:0];
                    sym_len_q  <= len_q;
                    state_q    <= StOut;
                end
                StOut: begin
                    if (sym_ready) begin
                        state_q <= StIdle;
                    end
                end
                StBuild: begin
                    bcode_q <= b_next_code;
                    bk_q    <= b_next_k;
                    if (build_len_q == BLW'(MAX_CODE_LEN - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        build_len_q <= build_len_q + BLW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_multi_table_decoder.sv
// Directed testbench for huffman_multi_table_decoder. Tables: 0 = JPEG luma DC,
// 1 = JPEG luma AC (truncated to lengths 2..4). Expected symbols are hand-derived.

module tb_huffman_multi_table_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic       cfg_is_bits;
    logic [1:0] cfg_table;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_build;
    logic       cfg_ready;
    logic [1:0] sel_table;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] sym_run;
    logic [3:0] sym_size;
    logic [4:0] sym_len;
    logic       sym_valid;
    logic       sym_ready;
    logic       err;

    int total = 0;
    int bad   = 0;

    huffman_multi_table_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_is_bits(cfg_is_bits),
        .cfg_table  (cfg_table),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_build  (cfg_build),
        .cfg_ready  (cfg_ready),
        .sel_table  (sel_table),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sym_run    (sym_run),
        .sym_size   (sym_size),
        .sym_len    (sym_len),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int t, input logic isb, input int a, input int d);
        cfg_table   = 2'(t);
        cfg_is_bits = isb;
        cfg_addr    = 8'(a);
        cfg_data    = 8'(d);
        cfg_we      = 1'b1;
        tick();
        cfg_we      = 1'b0;
    endtask

    task automatic load_dc(input int t);
        int cnt [16] = '{0, 1, 5, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 16; i++) cfg_write(t, 1'b1, i, cnt[i]);
        for (int i = 0; i < 12; i++) cfg_write(t, 1'b0, i, i);
    endtask

    task automatic load_ac(input int t);
        int cnt [16] = '{0, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int hv [6]   = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h11};
        for (int i = 0; i < 16; i++) cfg_write(t, 1'b1, i, cnt[i]);
        for (int i = 0; i < 6; i++) cfg_write(t, 1'b0, i, hv[i]);
    endtask

    task automatic build(input int t, output int cyc);
        cfg_table = 2'(t);
        cfg_build = 1'b1;
        tick();
        cfg_build = 1'b0;
        cyc = 0;
        while (!cfg_ready && cyc < 100) begin
            cyc++;
            tick();
        end
    endtask

    task automatic send_bit(input logic b);
        int n = 0;
        in_bit   = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            n++;
            tick();
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_code(input int t, input logic [15:0] bits, input int len);
        sel_table = 2'(t);
        for (int i = len - 1; i >= 0; i--) send_bit(bits[i]);
    endtask

    task automatic get_sym(output logic [3:0] r, output logic [3:0] s, output logic [4:0] l,
                           output logic ok);
        int n = 0;
        while (!sym_valid && n < 50) begin
            n++;
            tick();
        end
        ok = sym_valid;
        r  = sym_run;
        s  = sym_size;
        l  = sym_len;
        sym_ready = 1'b1;
        tick();
        sym_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({in_ready, cfg_ready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_ready: got %b expected 11", {in_ready, cfg_ready});
        end
        total++;
        if ({sym_valid, err} !== 2'b00) begin
            bad++;
            $display("FAIL reset_flags: got %b expected 00", {sym_valid, err});
        end
        total++;
        if ({sym_run, sym_size, sym_len} !== 13'd0) begin
            bad++;
            $display("FAIL reset_sym: got %h expected 0", {sym_run, sym_size, sym_len});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_dc();
        int          cyc;
        logic [3:0]  r, s;
        logic [4:0]  l;
        logic        ok;
        logic [15:0] codes [3] = '{16'b00, 16'b1110, 16'b011};
        int          lens  [3] = '{2, 4, 3};
        logic [12:0] exp   [3] = '{{4'd0, 4'd0, 5'd2}, {4'd0, 4'd6, 5'd4}, {4'd0, 4'd2, 5'd3}};
        load_dc(0);
        build(0, cyc);
        total++;
        if (cyc !== 16) begin
            bad++;
            $display("FAIL dc_build_cycles: got %0d expected 16", cyc);
        end
        for (int i = 0; i < 3; i++) begin
            send_code(0, codes[i], lens[i]);
            if (i == 0) begin
                total++;
                if (sym_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL dc_latency_lookup: got sym_valid=%b expected 0", sym_valid);
                end
                tick();
                total++;
                if (sym_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL dc_latency_out: got sym_valid=%b expected 1", sym_valid);
                end
            end
            get_sym(r, s, l, ok);
            total++;
            if ({ok, r, s, l} !== {1'b1, exp[i]}) begin
                bad++;
                $display("FAIL dc_sym%0d: got ok=%b run=%0d size=%0d len=%0d expected run=%0d size=%0d len=%0d",
                         i, ok, r, s, l, exp[i][12:9], exp[i][8:5], exp[i][4:0]);
            end
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL dc_no_err: got %b expected 0", err);
        end
    endtask

    task automatic test_ac();
        int          cyc;
        logic [3:0]  r, s;
        logic [4:0]  l;
        logic        ok;
        logic [15:0] codes [3] = '{16'b1010, 16'b1100, 16'b00};
        int          lens  [3] = '{4, 4, 2};
        logic [12:0] exp   [3] = '{{4'd0, 4'd0, 5'd4}, {4'd1, 4'd1, 5'd4}, {4'd0, 4'd1, 5'd2}};
        load_ac(1);
        build(1, cyc);
        for (int i = 0; i < 3; i++) begin
            send_code(1, codes[i], lens[i]);
            get_sym(r, s, l, ok);
            total++;
            if ({ok, r, s, l} !== {1'b1, exp[i]}) begin
                bad++;
                $display("FAIL ac_sym%0d: got ok=%b run=%0d size=%0d len=%0d expected run=%0d size=%0d len=%0d",
                         i, ok, r, s, l, exp[i][12:9], exp[i][8:5], exp[i][4:0]);
            end
        end
    endtask

    task automatic test_build_only();
        int         n = 0;
        logic       in_low = 1'b1;
        logic [3:0] r, s;
        logic [4:0] l;
        logic       ok;
        cfg_table = 2'd1;
        cfg_build = 1'b1;
        tick();
        cfg_build = 1'b0;
        while (!cfg_ready && n < 100) begin
            if (in_ready) in_low = 1'b0;
            if (n == 3) begin
                // Must be ignored: would overwrite the EOB symbol.
                cfg_is_bits = 1'b0;
                cfg_addr    = 8'd3;
                cfg_data    = 8'h55;
                cfg_we      = 1'b1;
            end
            n++;
            tick();
            cfg_we = 1'b0;
        end
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL build_busy_cycles: got %0d expected 16", n);
        end
        total++;
        if ({in_low, in_ready} !== 2'b11) begin
            bad++;
            $display("FAIL build_in_ready: got low_during=%b after=%b expected 1 1", in_low, in_ready);
        end
        send_code(1, 16'b1010, 4);
        get_sym(r, s, l, ok);
        total++;
        if ({ok, r, s, l} !== {1'b1, 4'd0, 4'd0, 5'd4}) begin
            bad++;
            $display("FAIL build_we_ignored: got ok=%b run=%0d size=%0d len=%0d expected 0 0 4",
                     ok, r, s, l);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] r, s;
        logic [4:0] l;
        logic       ok;
        send_code(0, 16'b011, 3);
        get_sym(r, s, l, ok);
        total++;
        if ({ok, r, s, l} !== {1'b1, 4'd0, 4'd2, 5'd3}) begin
            bad++;
            $display("FAIL b2b_dc: got ok=%b run=%0d size=%0d len=%0d expected 0 2 3", ok, r, s, l);
        end
        // sel_table counts only with the first bit.
        sel_table = 2'd1;
        send_bit(1'b1);
        sel_table = 2'd0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        get_sym(r, s, l, ok);
        total++;
        if ({ok, r, s, l} !== {1'b1, 4'd1, 4'd1, 5'd4}) begin
            bad++;
            $display("FAIL b2b_ac_sel: got ok=%b run=%0d size=%0d len=%0d expected 1 1 4", ok, r, s, l);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] r, s;
        logic [4:0] l;
        logic       ok;
        send_code(0, 16'b1110, 4);
        tick();
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({sym_valid, in_ready, sym_run, sym_size, sym_len} !== {2'b10, 4'd0, 4'd6, 5'd4}) begin
                bad++;
                $display("FAIL bp_hold%0d: got valid=%b in_ready=%b run=%0d size=%0d len=%0d expected 1 0 0 6 4",
                         i, sym_valid, in_ready, sym_run, sym_size, sym_len);
            end
            tick();
        end
        get_sym(r, s, l, ok);
        total++;
        if ({ok, r, s, l} !== {1'b1, 4'd0, 4'd6, 5'd4}) begin
            bad++;
            $display("FAIL bp_release: got ok=%b run=%0d size=%0d len=%0d expected 0 6 4", ok, r, s, l);
        end
        total++;
        if (sym_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drop: got sym_valid=%b expected 0", sym_valid);
        end
    endtask

    task automatic test_bubbles();
        logic [3:0] r, s;
        logic [4:0] l;
        logic       ok;
        logic [2:0] pat = 3'b011;
        sel_table = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            tick();
            tick();
            send_bit(pat[i]);
        end
        get_sym(r, s, l, ok);
        total++;
        if ({ok, r, s, l} !== {1'b1, 4'd0, 4'd2, 5'd3}) begin
            bad++;
            $display("FAIL bubbles: got ok=%b run=%0d size=%0d len=%0d expected 0 2 3", ok, r, s, l);
        end
    endtask

    // Feeds the remaining bits of a never-matching code and checks its outcome.
    task automatic check_overlong(input string name, input logic [3:0] exp_size);
`ifdef HUFF_ERR_CHECK_EN
        logic seen = 1'b0;
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL %s_err: got %b expected 1", name, err);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (sym_valid) seen = 1'b1;
        end
        total++;
        if ({err, seen, in_ready} !== 3'b001) begin
            bad++;
            $display("FAIL %s_after_err: got err=%b sym_seen=%b in_ready=%b expected 0 0 1",
                     name, err, seen, in_ready);
        end
`else
        logic [3:0] r, s;
        logic [4:0] l;
        logic       ok;
        get_sym(r, s, l, ok);
        total++;
        if ({ok, r, s, l, err} !== {1'b1, 4'd0, exp_size, 5'd16, 1'b0}) begin
            bad++;
            $display("FAIL %s_sym: got ok=%b run=%0d size=%0d len=%0d err=%b expected 0 %0d 16 0",
                     name, ok, r, s, l, err, exp_size);
        end
`endif
    endtask

    task automatic test_overlong();
        send_code(0, 16'hFFFF, 16);
        check_overlong("dc_overlong", 4'd0);
        send_code(1, 16'hFFFF, 16);
        check_overlong("ac_overlong", 4'd1);
    endtask

    task automatic check_unbuilt(input string name);
        int         cyc;
        logic [3:0] r, s;
        logic [4:0] l;
        logic       ok;
        send_code(0, 16'b00, 2);
        tick();
        tick();
        total++;
        if ({sym_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL %s_00_nomatch: got sym_valid=%b in_ready=%b expected 0 1",
                     name, sym_valid, in_ready);
        end
        send_code(0, 16'h0000, 14);
        check_overlong(name, 4'd0);
        build(0, cyc);
        send_code(0, 16'b00, 2);
        get_sym(r, s, l, ok);
        total++;
        if ({ok, r, s, l} !== {1'b1, 4'd0, 4'd0, 5'd2}) begin
            bad++;
            $display("FAIL %s_rebuilt: got ok=%b run=%0d size=%0d len=%0d expected 0 0 2",
                     name, ok, r, s, l);
        end
    endtask

    task automatic test_reset_mid_code();
        send_code(0, 16'b11, 2);
        rst = 1'b1;
        #2;
        total++;
        if ({in_ready, cfg_ready, sym_valid, err, sym_run, sym_size, sym_len} !==
            {4'b1100, 13'd0}) begin
            bad++;
            $display("FAIL rst_code_vals: got rdy=%b crdy=%b v=%b e=%b run=%0d size=%0d len=%0d expected 1 1 0 0 0 0 0",
                     in_ready, cfg_ready, sym_valid, err, sym_run, sym_size, sym_len);
        end
        rst = 1'b0;
        tick();
        check_unbuilt("rst_code");
    endtask

    task automatic test_reset_mid_build();
        cfg_table = 2'd0;
        cfg_build = 1'b1;
        tick();
        cfg_build = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #2;
        total++;
        if ({in_ready, cfg_ready, sym_valid, err} !== 4'b1100) begin
            bad++;
            $display("FAIL rst_build_vals: got rdy=%b crdy=%b v=%b e=%b expected 1 1 0 0",
                     in_ready, cfg_ready, sym_valid, err);
        end
        rst = 1'b0;
        tick();
        check_unbuilt("rst_build");
    endtask

    initial begin
        rst         = 1'b1;
        cfg_we      = 1'b0;
        cfg_is_bits = 1'b0;
        cfg_table   = 2'd0;
        cfg_addr    = 8'd0;
        cfg_data    = 8'd0;
        cfg_build   = 1'b0;
        sel_table   = 2'd0;
        in_bit      = 1'b0;
        in_valid    = 1'b0;
        sym_ready   = 1'b0;
        test_reset();
        test_dc();
        test_ac();
        test_build_only();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_overlong();
        test_reset_mid_code();
        test_reset_mid_build();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
